// File: rtl/nios_mult_seq_unit.sv
// Iterative multiplier for the Nios ALU custom-unit slot.
// A single PART_W x PART_W unsigned multiplier is reused over K*K cycles.
// Signed operands are handled as magnitude and sign: the unsigned magnitude
// product is accumulated, and then negated once at the end if needed.
module nios_mult_seq_unit #(
    parameter int DATA_W = 32,
    parameter int PART_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              busy
);

    localparam int K  = DATA_W / PART_W;
    localparam int NP = K * K;
    localparam int CW = (NP > 1) ? $clog2(NP) : 1;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = 2 * DATA_W;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef logic [K-1:0][PART_W-1:0] chunks_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     acc_q;
    chunks_t           a_mag_q, b_mag_q;
    logic              neg_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] res_q;

    logic              accept;
    logic              last;
    logic              neg1, neg2;
    logic [DATA_W-1:0] mag1, mag2;
    logic [IW-1:0]     i_idx, j_idx;
    logic [2*PART_W-1:0] prod;
    logic [31:0]       sh;
    logic [PW-1:0]     pp_sh;
    logic [PW-1:0]     acc_sum;
    logic [PW-1:0]     full;

    // Flush blocks an accept even though in_ready is still asserted in IDLE.
    assign accept = in_valid & in_ready & ~flush;
    assign last   = (state_q == S_CALC) && (cnt_q == CW'(NP - 1));

    // Operand decode: sign of each source depends on the opcode; MUL is unsigned.
    always_comb begin
        neg1 = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) & in_src1[DATA_W-1];
        neg2 = (in_op == OP_MULH) & in_src2[DATA_W-1];
        mag1 = neg1 ? -in_src1 : in_src1;
        mag2 = neg2 ? -in_src2 : in_src2;
    end

    // One partial product per cycle, shifted to its chunk position and summed.
    always_comb begin
        i_idx   = IW'(cnt_q / CW'(K));
        j_idx   = IW'(cnt_q % CW'(K));
        prod    = a_mag_q[i_idx] * b_mag_q[j_idx];
        sh      = PART_W * (32'(i_idx) + 32'(j_idx));
        pp_sh   = PW'(prod) << sh;
        acc_sum = acc_q + pp_sh;
        full    = neg_q ? -acc_sum : acc_sum;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; flush wins over every handshake.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept)    state_d = S_CALC;
                S_CALC:  if (last)      state_d = S_DONE;
                S_DONE:  if (out_ready) state_d = S_IDLE;
                default:                state_d = S_IDLE;
            endcase
        end
    end

    // Handshake outputs are pure functions of the state.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    assign out_result = res_q;

    // Datapath: latch operands on accept, accumulate in CALC, and select the half on the last step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            neg_q   <= 1'b0;
            op_q    <= OP_MUL;
            res_q   <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_mag_q <= mag1;
                        b_mag_q <= mag2;
                        neg_q   <= neg1 ^ neg2;
                        op_q    <= in_op;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + 1'b1;
                    if (last)
                        res_q <= (op_q == OP_MUL) ? full[DATA_W-1:0] : full[PW-1:DATA_W];
                end
                default: ;
            endcase
        end
    end

endmodule
